rom_burst_reader: RTL

Sequencing front-end for the 1 KB sky130 OpenROM macro. On a start command it issues consecutive single-word reads to the ROM port (`rom_cs`/`rom_addr`), captures each returned byte, and delivers the bytes in order on a valid/ready stream through a small internal FIFO. It sits directly upstream of the ROM macro, drives its read port, and is the only consumer of its `dout`.

---
 rtl/rom_burst_reader.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/rom_burst_reader.sv
// Burst read sequencer for the 1 KB OpenROM macro: issues credit-gated reads and streams bytes out.
// Optional burst checksum enabled by defining ROM_BURST_CHECKSUM_EN.
module rom_burst_reader #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 11,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [LEN_WIDTH-1:0]  length,
    output logic                  busy,
    output logic                  done,
    output logic                  rom_cs,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_dout,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic [15:0]           checksum
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [LEN_WIDTH-1:0]  to_issue;
    logic                  inflight_last;

    logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_last;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_after;
    logic                  push;
    logic                  pop;
    logic                  credit;

    // A read in flight always lands in the FIFO at the end of its cycle, so credit
    // is judged on the occupancy after this edge's push/pop.
    assign push        = rom_cs;
    assign pop         = out_valid & out_ready;
    assign count_after = count + CW'(push) - CW'(pop);
    assign credit      = count_after < CW'(FIFO_DEPTH);

    assign out_valid = (count != '0);
    assign out_data  = fifo_data[rd_ptr];
    assign out_last  = out_valid & fifo_last[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            rom_cs        <= 1'b0;
            rom_addr      <= '0;
            next_addr     <= '0;
            to_issue      <= '0;
            inflight_last <= 1'b0;
        end else begin
            done   <= 1'b0;
            rom_cs <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (length == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            busy          <= 1'b1;
                            rom_cs        <= 1'b1;
                            rom_addr      <= start_addr;
                            next_addr     <= start_addr + ADDR_WIDTH'(1);
                            to_issue      <= length - LEN_WIDTH'(1);
                            inflight_last <= (length == LEN_WIDTH'(1));
                            state         <= (length == LEN_WIDTH'(1)) ? DRAIN : READ;
                        end
                    end
                end
                READ: begin
                    if (credit) begin
                        rom_cs        <= 1'b1;
                        rom_addr      <= next_addr;
                        next_addr     <= next_addr + ADDR_WIDTH'(1);
                        to_issue      <= to_issue - LEN_WIDTH'(1);
                        inflight_last <= (to_issue == LEN_WIDTH'(1));
                        if (to_issue == LEN_WIDTH'(1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && out_last) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // ROM data is only captured in the cycle after an issued read; idle cycles carry X.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data[i] <= '0;
            end
            fifo_last <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= rom_dout;
                fifo_last[wr_ptr] <= inflight_last;
                wr_ptr            <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count_after;
        end
    end

`ifdef ROM_BURST_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum <= '0;
        end else if (state == IDLE && start) begin
            checksum <= '0;
        end else if (pop) begin
            checksum <= checksum + 16'(out_data);
        end
    end
`else
    assign checksum = '0;
`endif

endmodule
